seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit common-anode 7-segment display that shares a single BCD-to-segment decoder (4-bit input, a..g outputs) across all digits. It holds a frame of BCD digits and presents one nibble at a time to the shared decoder while driving a one-hot digit-enable. It inserts a blanking guard between digits to suppress ghosting and commits new data only at frame boundaries, so a frame never mixes old and new digits. It optionally suppresses leading zeros.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
REFRESH_DIV, 50000, clock cycles each digit is lit (>=1)
BLANK_CYCLES, 16, clock cycles all digits are off before each digit slot (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  1 = scanning; 0 = display dark, scan returns to idle
load  input  1  single-cycle strobe; captures digits_in into the pending register
digits_in  input  4*NUM_DIGITS  BCD digits; nibble 0 [3:0] is least significant
lzb  input  1  leading-zero blanking enable
bcd_out  output  4  nibble for the shared decoder (registered)
digit_an  output  NUM_DIGITS  one-hot digit enable, active high (registered)
frame_done  output  1  one-cycle pulse at the end of the last digit slot
busy  output  1  1 whenever state != IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; idx=0; cnt=0; display_reg=0; pending_reg=0; pending_valid=0; bcd_out=0; digit_an=0; frame_done=0; busy=0.
- States: IDLE, BLANK, SHOW. All outputs are registered.
- IDLE: digit_an=0. If enable=1, the next cycle enters BLANK with idx=0 and cnt=0.
- BLANK: lasts exactly BLANK_CYCLES cycles (cnt 0..BLANK_CYCLES-1). digit_an=0. bcd_out=display_reg nibble[idx]. At the last count, the next cycle enters SHOW with cnt=0.
- SHOW: lasts exactly REFRESH_DIV cycles. digit_an[idx]=1, all other bits 0, unless the digit is suppressed (see below). bcd_out is held. At the last count:
  - if idx=NUM_DIGITS-1: idx wraps to 0 and frame_done=1 for one cycle, coincident with the first BLANK cycle;
  - otherwise idx increments.
  - The next state is BLANK.
- Slot period: BLANK_CYCLES+REFRESH_DIV cycles. Frame period: NUM_DIGITS times the slot period.
- First-light latency: enable is sampled high in IDLE, then digit_an[0] goes high BLANK_CYCLES+1 cycles later.
- Data commit:
  - load=1 sets pending_reg=digits_in and pending_valid=1. A later load overwrites earlier data; the last load wins.
  - On entry to BLANK with idx=0, including from IDLE: if pending_valid=1, display_reg takes pending_reg and pending_valid clears.
  - If load=1 in the same cycle as a commit, digits_in bypasses to display_reg directly and pending_valid stays 0.
  - display_reg never changes at any other time.
- Digit suppression:
  - Digit i is suppressed when its nibble is greater than 9.
  - Digit i is also suppressed when lzb=1, i!=0, and nibbles NUM_DIGITS-1..i are all zero.
  - Digit 0 is never zero-suppressed.
  - A suppressed digit keeps its slot timing but digit_an stays 0 for the whole slot.
- enable drops in BLANK or SHOW: the next cycle is IDLE with digit_an=0, idx=0, cnt=0, frame_done=0. pending_valid is retained.
- Reset mid-frame: all state and outputs return to their reset values immediately; the pending load is lost.
- Invariant: at most one digit_an bit is set in any cycle. digit_an is 0 for at least BLANK_CYCLES cycles between any two different digits being lit.

Test Plan:
(Parameters for all scenarios: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2.)
1. Basic scan:
   - Stimulus: rst_n release; load with digits_in=16'h1234; enable=1.
   - Response: digit_an goes 0001, 0010, 0100, 1000, each lit 4 cycles after 2 dark cycles, with bcd_out=4, 3, 2, 1. frame_done pulses every 24 cycles.
2. Frame-boundary commit:
   - Stimulus: load 16'h5678 while digit 1 is lit.
   - Response: digits 2 and 3 still show 2 and 1. The next frame shows 8, 7, 6, 5.
3. Leading-zero blanking:
   - Stimulus: digits 16'h0050 with lzb=1.
   - Response: digit 0 is lit with bcd_out=0 and digit 1 is lit with bcd_out=5. digit_an stays 0 during the slots of digits 2 and 3. Frame period is unchanged at 24 cycles.
   - Stimulus: digits 16'h0000 with lzb=1.
   - Response: only digit 0 lights, showing 0.
4. Invalid nibble:
   - Stimulus: digits 16'h12A4.
   - Response: the digit-1 slot is dark (digit_an=0). The other three digits show normally.
5. Enable drop:
   - Stimulus: enable=0 during the 2nd SHOW cycle of digit 2.
   - Response: the next cycle has digit_an=0, busy=0, and no frame_done.
   - Stimulus: enable re-asserted.
   - Response: the scan restarts at digit 0 after 3 cycles.
6. Async reset:
   - Stimulus: rst_n=0 mid-SHOW, between clock edges.
   - Response: digit_an=0 and bcd_out=0 immediately. After release, display_reg=0 until a new load.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed 7-segment scan with blanking guard, frame-boundary commit and leading-zero blanking
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    lzb,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_an,
  output logic                    frame_done,
  output logic                    busy
);
  localparam int CW = $clog2((REFRESH_DIV > BLANK_CYCLES ? REFRESH_DIV : BLANK_CYCLES) + 1);
  localparam int IW = $clog2(NUM_DIGITS);
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [4*NUM_DIGITS-1:0] display_reg, pending_reg, disp_nxt;
  logic pending_valid, commit, fd_nxt, last_digit, z;
  logic [NUM_DIGITS-1:0] sup, an_nxt;
  assign last_digit = idx == IW'(NUM_DIGITS - 1);
  assign busy = state != IDLE;
  always_comb begin
    state_nxt = state;
    idx_nxt = idx;
    cnt_nxt = cnt + 1'b1;
    fd_nxt = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
      idx_nxt = '0;
      cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = BLANK;
          idx_nxt = '0;
          cnt_nxt = '0;
        end
        BLANK: if (cnt == CW'(BLANK_CYCLES - 1)) begin
          state_nxt = SHOW;
          cnt_nxt = '0;
        end
        SHOW: if (cnt == CW'(REFRESH_DIV - 1)) begin
          state_nxt = BLANK;
          cnt_nxt = '0;
          idx_nxt = last_digit ? '0 : idx + 1'b1;
          fd_nxt = last_digit;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end
  // new data lands only when a frame (re)starts, so a frame never mixes old and new digits
  assign commit = state_nxt == BLANK && state != BLANK && idx_nxt == '0;
  assign disp_nxt = !commit ? display_reg : load ? digits_in : pending_valid ? pending_reg : display_reg;
  // walk from the most significant digit down, tracking whether everything above is zero
  always_comb begin
    z = 1'b1;
    sup = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      z = z & (disp_nxt[4*i +: 4] == 4'd0);
      sup[i] = (disp_nxt[4*i +: 4] > 4'd9) | (lzb && i != 0 && z);
    end
  end
  assign an_nxt = (state_nxt == SHOW && !sup[idx_nxt]) ? NUM_DIGITS'(1) << idx_nxt : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      display_reg <= '0;
      pending_reg <= '0;
      pending_valid <= 1'b0;
      bcd_out <= '0;
      digit_an <= '0;
      frame_done <= 1'b0;
    end else begin
      state <= state_nxt;
      idx <= idx_nxt;
      cnt <= cnt_nxt;
      display_reg <= disp_nxt;
      if (load) pending_reg <= digits_in;
      pending_valid <= commit ? 1'b0 : (load | pending_valid);
      bcd_out <= state_nxt == BLANK ? disp_nxt[4*idx_nxt +: 4] : bcd_out;
      digit_an <= an_nxt;
      frame_done <= fd_nxt;
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed and random stimulus checked against a time-based scan model
module tb_seg7_scan_ctrl;
  localparam int N = 4, R = 4, B = 2, SLOT = R + B, FRAME = N * SLOT;
  logic clk = 0, rst_n = 0, enable = 0, load = 0, lzb = 0;
  logic [15:0] digits_in = '0;
  logic [3:0] bcd_out;
  logic [3:0] digit_an;
  logic frame_done, busy;
  int n_cmp = 0, n_err = 0;
  bit m_run = 0, m_pv = 0, m_lzb = 0;
  int m_t = 0;
  logic [15:0] m_disp = '0, m_pend = '0;

  seg7_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .digits_in(digits_in),
    .lzb(lzb), .bcd_out(bcd_out), .digit_an(digit_an), .frame_done(frame_done), .busy(busy));

  always #5 clk = ~clk;

  function automatic bit supp(logic [15:0] d, int s, bit lz);
    logic [15:0] above;
    above = d >> (4 * s);
    return (above[3:0] > 9) || (lz && s != 0 && above == 0);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pv = 0; m_t = 0; m_disp = '0; m_pend = '0;
  endtask

  task automatic cycle();
    int slot, ph;
    logic [15:0] sh;
    @(posedge clk);
    m_lzb = lzb;
    if (!enable) m_run = 0;
    else begin
      m_t = m_run ? m_t + 1 : 0;
      m_run = 1;
    end
    if (m_run && m_t % FRAME == 0) begin
      if (load) begin m_disp = digits_in; m_pv = 0; end
      else if (m_pv) begin m_disp = m_pend; m_pv = 0; end
    end else if (load) begin
      m_pend = digits_in; m_pv = 1;
    end
    @(negedge clk);
    slot = (m_t / SLOT) % N;
    ph = m_t % SLOT;
    sh = m_disp >> (4 * slot);
    chk("digit_an", 32'(digit_an),
        (m_run && ph >= B && !supp(m_disp, slot, m_lzb)) ? 32'(1) << slot : 0);
    chk("frame_done", 32'(frame_done), 32'(m_run && m_t > 0 && m_t % FRAME == 0));
    chk("busy", 32'(busy), 32'(m_run));
    chk("onehot0", 32'($onehot0(digit_an)), 1);
    if (m_run) chk("bcd_out", 32'(bcd_out), 32'(sh[3:0]));
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic do_load(logic [15:0] d);
    digits_in = d; load = 1;
    cycle();
    load = 0;
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] d;
    for (int i = 0; i < 4; i++) d[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 11));
    return d;
  endfunction

  initial begin
    int k;
    // reset state
    #12;
    chk("rst_an", 32'(digit_an), 0);
    chk("rst_bcd", 32'(bcd_out), 0);
    chk("rst_fd", 32'(frame_done), 0);
    chk("rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1;
    run(3);
    // basic scan, also first-light latency
    do_load(16'h1234);
    enable = 1;
    k = 0;
    while (digit_an[0] !== 1'b1 && k < 10) begin cycle(); k++; end
    chk("first_light", 32'(k), B + 1);
    run(60);
    // load while digit 1 lit commits only at next frame
    k = 0;
    while (!(m_run && (m_t / SLOT) % N == 1 && m_t % SLOT >= B) && k < 50) begin cycle(); k++; end
    chk("wait_d1", 32'(k < 50), 1);
    do_load(16'h5678);
    run(50);
    // leading-zero blanking
    lzb = 1;
    do_load(16'h0050);
    run(50);
    do_load(16'h0000);
    run(30);
    lzb = 0;
    // invalid nibble
    do_load(16'h12A4);
    run(30);
    // enable drop in 2nd SHOW cycle of digit 2
    k = 0;
    while (!(m_run && m_t % FRAME == 2 * SLOT + B + 1) && k < 50) begin cycle(); k++; end
    chk("wait_d2", 32'(k < 50), 1);
    enable = 0;
    cycle();
    chk("drop_an", 32'(digit_an), 0);
    chk("drop_busy", 32'(busy), 0);
    run(3);
    enable = 1;
    k = 0;
    while (digit_an === 4'd0 && k < 10) begin cycle(); k++; end
    chk("restart_lat", 32'(k), B + 1);
    chk("restart_d0", 32'(digit_an), 1);
    run(30);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin digits_in = rand_digits(); load = 1; end
      if ($urandom_range(0, 40) == 0) lzb = ~lzb;
      if ($urandom_range(0, 60) == 0) enable = ~enable;
      cycle();
      load = 0;
      if (!enable && $urandom_range(0, 3) == 0) enable = 1;
    end
    enable = 1;
    lzb = 0;
    // async reset mid-SHOW
    k = 0;
    while (!(m_run && m_t % SLOT == B + 1) && k < 100) begin cycle(); k++; end
    chk("wait_show", 32'(k < 100), 1);
    do_load(16'h9999);
    #2 rst_n = 0;
    #1;
    chk("arst_an", 32'(digit_an), 0);
    chk("arst_bcd", 32'(bcd_out), 0);
    chk("arst_busy", 32'(busy), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    run(40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
